// File: rtl/systolic_mm4x4.sv
// 4x4 output-stationary systolic array: C = A x B on unsigned 8-bit operands.
// Operands arrive pre-skewed. Each PE accumulates one C(i,j) until the cycle counter declares done.
module systolic_mm4x4 #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         in_up1,
  input  logic [DW-1:0]         in_up2,
  input  logic [DW-1:0]         in_up3,
  input  logic [DW-1:0]         in_up4,
  input  logic [DW-1:0]         in_left1,
  input  logic [DW-1:0]         in_left2,
  input  logic [DW-1:0]         in_left3,
  input  logic [DW-1:0]         in_left4,
  output logic                  done,
  output logic [N*N*ACC_W-1:0]  c_flat
);

  // Cycle on which the final product reaches PE(N,N). done rises on that edge.
  localparam logic [3:0] LAST_CYCLE = 4'(3*N - 3);

  logic [N*DW-1:0]       left_edge;
  logic [N*DW-1:0]       up_edge;
  // right_bus holds the right_q of PE(gi,gj) for gj < N-1, at slot gi*(N-1)+gj.
  // down_bus holds the down_q of PE(gi,gj) for gi < N-1, at slot gi*N+gj.
  logic [N*(N-1)*DW-1:0] right_bus;
  logic [(N-1)*N*DW-1:0] down_bus;
  logic [3:0]            cnt_reg;
  logic                  done_reg;

  assign left_edge = {in_left4, in_left3, in_left2, in_left1};
  assign up_edge   = {in_up4, in_up3, in_up2, in_up1};
  assign done      = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      if (cnt_reg != 4'hF) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
      if (cnt_reg == LAST_CYCLE) begin
        done_reg <= 1'b1;
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic [DW-1:0]    left_in;
        logic [DW-1:0]    up_in;
        logic [2*DW-1:0]  prod;
        logic [ACC_W-1:0] acc_reg;

        if (gj == 0) begin : g_left_edge
          assign left_in = left_edge[gi*DW +: DW];
        end else begin : g_left_pe
          assign left_in = right_bus[(gi*(N-1) + gj - 1)*DW +: DW];
        end

        if (gi == 0) begin : g_up_edge
          assign up_in = up_edge[gj*DW +: DW];
        end else begin : g_up_pe
          assign up_in = down_bus[((gi-1)*N + gj)*DW +: DW];
        end

        assign prod = left_in * up_in;

        always_ff @(posedge clk) begin
          if (rst) begin
            acc_reg <= '0;
          end else if (!done_reg) begin
            acc_reg <= acc_reg + {{(ACC_W-2*DW){1'b0}}, prod};
          end
        end

        // The last column's right_q and the last row's down_q feed nothing, so they are not built.
        if (gj < N-1) begin : g_right
          logic [DW-1:0] right_reg;
          always_ff @(posedge clk) begin
            if (rst) begin
              right_reg <= '0;
            end else begin
              right_reg <= left_in;
            end
          end
          assign right_bus[(gi*(N-1) + gj)*DW +: DW] = right_reg;
        end

        if (gi < N-1) begin : g_down
          logic [DW-1:0] down_reg;
          always_ff @(posedge clk) begin
            if (rst) begin
              down_reg <= '0;
            end else begin
              down_reg <= up_in;
            end
          end
          assign down_bus[(gi*N + gj)*DW +: DW] = down_reg;
        end

        assign c_flat[(gi*N + gj)*ACC_W +: ACC_W] = acc_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_systolic_mm4x4.sv
// Directed bench for systolic_mm4x4. Matrices are fed skewed and results are checked against hand-computed values.
module tb_systolic_mm4x4;

  logic         clk;
  logic         rst;
  logic [7:0]   up_v   [4];
  logic [7:0]   left_v [4];
  logic         done;
  logic [287:0] c_flat;

  int tests;
  int fails;

  int cur_a  [4][4];   // cur_a[i][k]  = A(i+1,k+1)
  int cur_b  [4][4];   // cur_b[j][k]  = B(k+1,j+1), stored as columns
  int exp_c  [4][4];

  int a_main [4][4] = '{'{10,9,7,5}, '{8,3,3,2}, '{3,2,10,8}, '{8,4,3,3}};
  int b_main [4][4] = '{'{3,9,12,3}, '{12,10,1,10}, '{4,12,4,12}, '{10,2,9,18}};
  int c_main [4][4] = '{'{210,267,236,271}, '{93,149,104,149},
                        '{171,146,172,268}, '{105,169,128,169}};

  systolic_mm4x4 dut (
    .clk      (clk),
    .rst      (rst),
    .in_up1   (up_v[0]),
    .in_up2   (up_v[1]),
    .in_up3   (up_v[2]),
    .in_up4   (up_v[3]),
    .in_left1 (left_v[0]),
    .in_left2 (left_v[1]),
    .in_left3 (left_v[2]),
    .in_left4 (left_v[3]),
    .done     (done),
    .c_flat   (c_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive_all(input logic [7:0] v);
    for (int i = 0; i < 4; i++) begin
      up_v[i]   = v;
      left_v[i] = v;
    end
  endtask

  // Present the skewed operands for stream cycle t (called between edges).
  task automatic drive_cycle(input int t);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = t - i;
      left_v[i] = (k >= 0 && k < 4) ? 8'(cur_a[i][k]) : 8'd0;
      up_v[i]   = (k >= 0 && k < 4) ? 8'(cur_b[i][k]) : 8'd0;
    end
  endtask

  // Release reset and run `cycles` stream cycles; optionally check done timing.
  task automatic run_stream(input string name, input int cycles, input bit check_done);
    rst = 1'b0;
    for (int t = 0; t < cycles; t++) begin
      drive_cycle(t);
      @(negedge clk);
      if (check_done && t == 8) chk({name, "_done_before_last"}, 32'(done), 32'd0);
      if (check_done && t == 9) chk({name, "_done_at_edge10"}, 32'(done), 32'd1);
    end
    drive_all(8'd0);
    $display("[TB] stream %s: %0d cycles applied, done=%0b", name, cycles, done);
  endtask

  task automatic check_c(input string name);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("%s_c%0d%0d", name, i+1, j+1),
            32'(c_flat[(i*4+j)*18 +: 18]), 32'(exp_c[i][j]));
      end
    end
  endtask

  task automatic apply_reset(input int edges);
    rst = 1'b1;
    drive_all(8'd0);
    repeat (edges) @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    drive_all(8'd0);

    // Reset state
    apply_reset(2);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_c_any_bit", 32'(|c_flat), 32'd0);

    // Main vector
    cur_a = a_main;
    cur_b = b_main;
    exp_c = c_main;
    run_stream("main", 12, 1'b1);
    check_c("main");

    // Freeze: saturating inputs after done must not change results
    drive_all(8'd255);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk($sformatf("freeze_done_%0d", t), 32'(done), 32'd1);
      $display("[TB] freeze cycle %0d: done=%0b", t, done);
    end
    check_c("freeze");

    // Max operands
    apply_reset(1);
    chk("rst2_done", 32'(done), 32'd0);
    chk("rst2_c_any_bit", 32'(|c_flat), 32'd0);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        cur_a[i][k] = 255;
        cur_b[i][k] = 255;
        exp_c[i][k] = 260100;
      end
    end
    run_stream("max", 12, 1'b1);
    check_c("max");

    // Identity A, B(k,j) = 4k+j, so C must equal B
    apply_reset(1);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        cur_a[i][k] = (i == k) ? 1 : 0;
        cur_b[i][k] = 4*(k+1) + (i+1);
        exp_c[k][i] = 4*(k+1) + (i+1);
      end
    end
    run_stream("ident", 12, 1'b1);
    check_c("ident");

    // Mid-run reset at stream cycle 5, then full replay of the main vector
    apply_reset(1);
    cur_a = a_main;
    cur_b = b_main;
    exp_c = c_main;
    run_stream("abort", 5, 1'b0);
    apply_reset(1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_c_any_bit", 32'(|c_flat), 32'd0);
    run_stream("replay", 12, 1'b1);
    check_c("replay");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
